// File: rtl/level_timed_data_capture.sv
`default_nettype none
// ============================================================================
// Module   : level_timed_data_capture
// Purpose  : Deserialises frames from a level-timed serial shifter into a
//            valid/ready output stage, flagging glitches, timeouts and overruns.
// Revision : 1.0 - initial release
// ============================================================================
module level_timed_data_capture #(
    parameter int DATA_W       = 8,
    parameter int SAMPLE_DLY   = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              sda,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic              glitch,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int HI_W  = 4;
    localparam int LO_W  = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [HI_W-1:0]  c_sample_dly = HI_W'(SAMPLE_DLY);
    localparam logic [LO_W-1:0]  c_timeout    = LO_W'(IDLE_TIMEOUT);
    localparam logic [BIT_W-1:0] c_last_bit   = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2,
        ST_DONE_HI = 2'd3
    } state_t;

    logic [1:0]        sclk_sync_q;
    logic [1:0]        sda_sync_q;
    state_t            state_q,    state_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [HI_W-1:0]   hi_cnt_q,   hi_cnt_d;
    logic [LO_W-1:0]   lo_cnt_q,   lo_cnt_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic              complete_q, complete_d;
    logic              glitch_q,   glitch_d;
    logic              frame_err_q, frame_err_d;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              overrun_q;

    logic              w_sclk_s;
    logic              w_sda_s;
    logic              w_take_sample;
    logic [HI_W-1:0]   w_hi_next;
    logic [LO_W-1:0]   w_lo_next;

    // Data sync idles high so a released line never looks like a 0 bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            sda_sync_q  <= 2'b11;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            sda_sync_q  <= {sda_sync_q[0], sda};
        end
    end

    assign w_sclk_s  = sclk_sync_q[1];
    assign w_sda_s   = sda_sync_q[1];
    assign w_hi_next = hi_cnt_q + 1'b1;
    assign w_lo_next = lo_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            shreg_q     <= '0;
            complete_q  <= 1'b0;
            glitch_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            shreg_q     <= shreg_d;
            complete_q  <= complete_d;
            glitch_q    <= glitch_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        shreg_d       = shreg_q;
        complete_d    = 1'b0;
        glitch_d      = 1'b0;
        frame_err_d   = 1'b0;
        w_take_sample = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOW: begin
                if (state_q == ST_IDLE) begin
                    bit_cnt_d = '0;
                end
                if (w_sclk_s) begin
                    lo_cnt_d = '0;
                    hi_cnt_d = HI_W'(1);
                    // The first high cycle already satisfies a one-cycle delay
                    if (SAMPLE_DLY == 1) begin
                        w_take_sample = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else if (state_q == ST_LOW) begin
                    lo_cnt_d = w_lo_next;
                    if ((bit_cnt_q != '0) && (w_lo_next == c_timeout)) begin
                        bit_cnt_d   = '0;
                        shreg_d     = '0;
                        lo_cnt_d    = '0;
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_HIGH: begin
                if (w_sclk_s) begin
                    hi_cnt_d = w_hi_next;
                    if (w_hi_next == c_sample_dly) begin
                        w_take_sample = 1'b1;
                    end
                end else begin
                    glitch_d = 1'b1;
                    lo_cnt_d = LO_W'(1);
                    state_d  = (bit_cnt_q == '0) ? ST_IDLE : ST_LOW;
                end
            end
            ST_DONE_HI: begin
                if (!w_sclk_s) begin
                    lo_cnt_d = LO_W'(1);
                    state_d  = (bit_cnt_q == '0) ? ST_IDLE : ST_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_take_sample) begin
            shreg_d = {shreg_q[DATA_W-2:0], w_sda_s};
            state_d = ST_DONE_HI;
            if (bit_cnt_q == c_last_bit) begin
                bit_cnt_d  = '0;
                complete_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // shreg is stable in DONE_HI, so it still holds the frame one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (complete_q) begin
                if (!out_valid_q || out_ready) begin
                    out_data_q  <= shreg_q;
                    out_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign glitch    = glitch_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/level_timed_data_capture.md
LEVEL_TIMED_DATA_CAPTURE -- requirements
Module: level_timed_data_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per frame.
REQ-002 The block SHALL have parameter SAMPLE_DLY, default 2, meaning consecutive synchronized-sclk-high clk cycles before sda is sampled (legal 1..15).
REQ-003 The block SHALL have parameter IDLE_TIMEOUT, default 64, meaning consecutive synchronized-sclk-low clk cycles that abort a partial frame (legal 2..1023).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sclk  input  1  serial clock from level-timed shifter; asynchronous to clk.
REQ-007 sda  input  1  serial data, MSB first; valid while sclk high.
REQ-008 out_data  output  DATA_W  last completed frame.
REQ-009 out_valid  output  1  out_data holds an unconsumed frame.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-011 overrun  output  1  one-cycle pulse: completed frame dropped.
REQ-012 frame_err  output  1  one-cycle pulse: partial frame aborted by timeout.
REQ-013 glitch  output  1  one-cycle pulse: sclk high pulse shorter than SAMPLE_DLY.
REQ-014 busy  output  1  high when state != IDLE.

Function
REQ-015 sclk and sda SHALL each pass through a 2-flop synchronizer (sclk_s, sda_s); synchronizer latency 2 clk cycles.
REQ-016 FSM states SHALL be IDLE, LOW, HIGH, DONE_HI.
REQ-017 IDLE: bit_cnt=0; on sclk_s 0->1 go HIGH with hi_cnt=1.
REQ-018 LOW: on sclk_s 0->1 go HIGH with hi_cnt=1, lo_cnt cleared; else lo_cnt increments.
REQ-019 HIGH: while sclk_s=1 hi_cnt increments; in the cycle hi_cnt equals SAMPLE_DLY, shreg <= {shreg[DATA_W-2:0], sda_s}, bit_cnt increments, go DONE_HI.
REQ-020 HIGH: sclk_s=0 before sample SHALL pulse glitch, leave shreg/bit_cnt unchanged, go LOW (or IDLE if bit_cnt=0).
REQ-021 DONE_HI: wait for sclk_s=0, then go LOW (or IDLE if bit_cnt was just wrapped to 0); further sclk high cycles take no additional samples.
REQ-022 When the sampled bit is bit DATA_W, the frame SHALL complete: bit_cnt wraps to 0; out_data/out_valid update on the next clk edge (1 cycle after sample).
REQ-023 Completion with out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: out_data <= frame, out_valid=1, no overrun.
REQ-024 Completion with out_valid=1 and out_ready=0: frame dropped, out_data unchanged, overrun pulses 1 cycle.
REQ-025 out_valid=1 and out_ready=1 without completion: out_valid clears next cycle; out_data held.
REQ-026 LOW with bit_cnt!=0 and lo_cnt reaching IDLE_TIMEOUT: bit_cnt=0, shreg cleared, frame_err pulses, go IDLE.
REQ-027 Pulses (overrun, frame_err, glitch) SHALL be registered and never asserted for more than one consecutive cycle per event.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, bit_cnt/hi_cnt/lo_cnt/shreg 0, out_data 0, out_valid 0, overrun/frame_err/glitch 0, busy 0, sclk sync flops 0, sda sync flops 1.
REQ-029 Reset mid-frame SHALL discard the partial frame and any held out_data; first frame after release captured from bit 0.

Verification
REQ-030 rst_n low after 4 bits of a frame -> all outputs 0 immediately; after release, 8 bits of 0x5A -> out_data=0x5A, out_valid=1.
REQ-031 sclk 5 high/5 low, sda 0xA5 MSB first, out_ready=0 -> out_valid rises 1 cycle after 8th sample, out_data=0xA5, held until out_ready=1, then out_valid=0 next cycle.
REQ-032 Frames 0x3C then 0xC3, out_ready=0 -> out_data stays 0x3C, overrun exactly one pulse, no out_valid drop.
REQ-033 0x3C held, 0xC3 completes in cycle with out_ready=1 -> out_data=0xC3, out_valid stays 1, overrun=0.
REQ-034 SAMPLE_DLY=2, sclk_s high 1 cycle between bits 2 and 3 -> glitch one pulse, bit_cnt unchanged; remaining bits yield correct byte.
REQ-035 3 bits then sclk low 64 cycles -> frame_err one pulse, busy=0; next frame 0x81 captured as 0x81.
